// File: rtl/bit_entry_debounce.sv
// Bit-entry front end for the 11011 detector: per-button sync + debounce,
// then a press/release FSM that turns clean presses into single bit strobes.

module bit_entry_debounce_btn #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk_i,
  input  logic clear_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced level matches the accepted one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      rise_q   <= stable_q & ~prev_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

module bit_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk_5M,
  input  logic       clear_n,
  input  logic       btn_1,
  input  logic       btn_0,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       err_pulse,
  output logic       busy,
  output logic [4:0] history
);

  localparam int NUM_BTN = 2;

  typedef enum logic {
    IDLE         = 1'b0,
    WAIT_RELEASE = 1'b1
  } state_t;

  logic [NUM_BTN-1:0] raw, stable, rise;
  state_t             state_q;
  logic               bit_valid_q, bit_value_q, err_q, busy_q;
  logic [4:0]         hist_q;

  // Index 1 is the '1' button so rise[1] doubles as the entered bit value.
  assign raw = {btn_1, btn_0};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      bit_entry_debounce_btn #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_btn (
        .clk_i    (clk_5M),
        .clear_ni (clear_n),
        .raw_i    (raw[g]),
        .stable_o (stable[g]),
        .rise_o   (rise[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_5M) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      hist_q      <= '0;
    end else begin
      bit_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (&rise) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= WAIT_RELEASE;
          end else if (|rise) begin
            bit_valid_q <= 1'b1;
            bit_value_q <= rise[1];
            hist_q      <= {hist_q[3:0], rise[1]};
            busy_q      <= 1'b1;
            state_q     <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // A late rise still counts as a conflict even on the release cycle.
          if (|rise) err_q <= 1'b1;
          if (~|stable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign err_pulse = err_q;
  assign busy      = busy_q;
  assign history   = hist_q;

endmodule
